// File: rtl/square_gen_if.sv
// Operand/result bundle for square_gen: the producer drives data/in_valid,
// and the squarer returns the registered square/out_valid.
interface square_gen_if #(
    parameter int N = 3
);
    logic [N-1:0]   data;
    logic           in_valid;
    logic [2*N-1:0] square;
    logic           out_valid;

    modport master (
        output data,
        output in_valid,
        input  square,
        input  out_valid
    );

    modport slave (
        input  data,
        input  in_valid,
        output square,
        output out_valid
    );
endinterface

// File: rtl/square_gen.sv
// Pipelined unsigned squarer: symmetric partial-product array summed by a
// generated binary adder tree, followed by one register stage.
module square_gen #(
    parameter int N = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    square_gen_if.slave bus
);
    localparam int W  = 2 * N;
    localparam int T  = N + (N * (N - 1)) / 2;
    localparam int LG = $clog2(T);
    localparam int P  = 1 << LG;

    typedef logic [W-1:0] sq_t;

    sq_t terms [T];
    sq_t square_d, square_q;
    logic out_valid_d, out_valid_q;
    sq_t sq_comb;

    // Diagonal a_i*a_i collapses to a_i at weight 2i; each off-diagonal pair
    // appears twice, so it lands once at weight i+j+1.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = i; j < N; j++) begin : g_col
            if (i == j) begin : g_diag
                assign terms[i] = sq_t'(bus.data[i]) << (2 * i);
            end else begin : g_off
                assign terms[N + i * (N - 1) - (i * (i - 1)) / 2 + (j - i - 1)] =
                    sq_t'(bus.data[i] & bus.data[j]) << (i + j + 1);
            end
        end
    end

    // Every partial sum is a subset of the full square, so W bits never overflow.
    for (genvar l = 0; l <= LG; l++) begin : g_lvl
        sq_t s [P >> l];
        for (genvar k = 0; k < (P >> l); k++) begin : g_node
            if (l == 0) begin : g_leaf
                if (k < T) begin : g_term
                    assign s[k] = terms[k];
                end else begin : g_pad
                    assign s[k] = '0;
                end
            end else begin : g_add
                assign s[k] = g_lvl[l-1].s[2*k] + g_lvl[l-1].s[2*k+1];
            end
        end
    end

    assign sq_comb = g_lvl[LG].s[0];

    always_comb begin
        square_d    = square_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            square_d    = sq_comb;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            square_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            square_q    <= square_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.square    = square_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_square_gen.sv
// Scoreboard bench for square_gen at N = 1, 3, 4, 8 and 16.
module tb_square_gen;
    logic clk;
    logic rst_n;

    square_gen_if #(.N(1))  if1 ();
    square_gen_if #(.N(3))  if3 ();
    square_gen_if #(.N(4))  if4 ();
    square_gen_if #(.N(8))  if8 ();
    square_gen_if #(.N(16)) if16 ();

    square_gen #(.N(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    square_gen #(.N(3))  u3  (.clk(clk), .rst_n(rst_n), .bus(if3));
    square_gen #(.N(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    square_gen #(.N(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    square_gen #(.N(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected entries are {out_valid, zero-extended square}.
    logic [32:0] q1[$], q3[$], q4[$], q8[$], q16[$];
    logic [32:0] e, act;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if3.data = 3'b111;
        if3.in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            q3.push_back({1'b0, 32'd0});
            tick();
            e = q3.pop_front();
            act = {if3.out_valid, 32'(if3.square)};
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL reset_hold%0d: got vld=%0b sq=%0d, expected vld=%0b sq=%0d",
                         k, act[32], act[31:0], e[32], e[31:0]);
            end
        end
        rst_n = 1'b1;
        q3.push_back({1'b1, 32'd49});
        tick();
        e = q3.pop_front();
        act = {if3.out_valid, 32'(if3.square)};
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL reset_release: got vld=%0b sq=%0d, expected vld=%0b sq=%0d",
                     act[32], act[31:0], e[32], e[31:0]);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_sq [8] = '{0, 1, 4, 9, 16, 25, 36, 49};
        if3.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if3.data = 3'(k);
            q3.push_back({1'b1, exp_sq[k]});
            tick();
            e = q3.pop_front();
            act = {if3.out_valid, 32'(if3.square)};
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL stream_d%0d: got vld=%0b sq=%0d, expected vld=%0b sq=%0d",
                         k, act[32], act[31:0], e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_hold();
        logic [2:0] d [3]   = '{3'd5, 3'd6, 3'bxxx};
        logic       v [3]   = '{1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            if3.data = d[k];
            if3.in_valid = v[k];
            q3.push_back({v[k], 32'd25});
            tick();
            e = q3.pop_front();
            act = {if3.out_valid, 32'(if3.square)};
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL hold_step%0d: got vld=%0b sq=%0d, expected vld=%0b sq=%0d",
                         k, act[32], act[31:0], e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_midreset();
        logic [2:0]  d  [4] = '{3'd6, 3'd7, 3'd7, 3'd7};
        logic        v  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic        r  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [32:0] ex [4] = '{{1'b1, 32'd36}, {1'b0, 32'd0}, {1'b0, 32'd0}, {1'b1, 32'd49}};
        for (int k = 0; k < 4; k++) begin
            if3.data = d[k];
            if3.in_valid = v[k];
            rst_n = r[k];
            q3.push_back(ex[k]);
            tick();
            e = q3.pop_front();
            act = {if3.out_valid, 32'(if3.square)};
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL midreset_step%0d: got vld=%0b sq=%0d, expected vld=%0b sq=%0d",
                         k, act[32], act[31:0], e[32], e[31:0]);
            end
        end
        rst_n = 1'b1;
        if3.in_valid = 1'b0;
    endtask

    task automatic test_n8_boundary();
        logic [7:0]  d  [3] = '{8'd255, 8'd128, 8'd1};
        logic [31:0] ex [3] = '{32'h0000_FE01, 32'd16384, 32'd1};
        if8.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if8.data = d[k];
            q8.push_back({1'b1, ex[k]});
            tick();
            e = q8.pop_front();
            act = {if8.out_valid, 32'(if8.square)};
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL n8_d%0d: got vld=%0b sq=%0d, expected vld=%0b sq=%0d",
                         d[k], act[32], act[31:0], e[32], e[31:0]);
            end
        end
        if8.in_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] m1 = 0, m4 = 0, m8 = 0, m16 = 0;
        logic        v1, v4, v8, v16;
        logic [0:0]  d1;
        logic [3:0]  d4;
        logic [7:0]  d8;
        logic [15:0] d16;
        for (int i = 0; i < 1000; i++) begin
            v1  = (i == 0) || ($urandom_range(0, 7) != 0);
            v4  = (i == 0) || ($urandom_range(0, 7) != 0);
            v8  = (i == 0) || ($urandom_range(0, 7) != 0);
            v16 = (i == 0) || ($urandom_range(0, 7) != 0);
            d1  = 1'($urandom);
            d4  = 4'($urandom);
            d8  = 8'($urandom);
            d16 = 16'($urandom);
            if1.data = d1;   if1.in_valid = v1;
            if4.data = d4;   if4.in_valid = v4;
            if8.data = d8;   if8.in_valid = v8;
            if16.data = d16; if16.in_valid = v16;
            if (v1)  m1  = 32'(d1) * 32'(d1);
            if (v4)  m4  = 32'(d4) * 32'(d4);
            if (v8)  m8  = 32'(d8) * 32'(d8);
            if (v16) m16 = 32'(d16) * 32'(d16);
            q1.push_back({v1, m1});
            q4.push_back({v4, m4});
            q8.push_back({v8, m8});
            q16.push_back({v16, m16});
            tick();
            e = q1.pop_front();
            act = {if1.out_valid, 32'(if1.square)};
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL rand_n1 i=%0d: got vld=%0b sq=%0d, expected vld=%0b sq=%0d",
                         i, act[32], act[31:0], e[32], e[31:0]);
            end
            e = q4.pop_front();
            act = {if4.out_valid, 32'(if4.square)};
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL rand_n4 i=%0d: got vld=%0b sq=%0d, expected vld=%0b sq=%0d",
                         i, act[32], act[31:0], e[32], e[31:0]);
            end
            e = q8.pop_front();
            act = {if8.out_valid, 32'(if8.square)};
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL rand_n8 i=%0d: got vld=%0b sq=%0d, expected vld=%0b sq=%0d",
                         i, act[32], act[31:0], e[32], e[31:0]);
            end
            e = q16.pop_front();
            act = {if16.out_valid, 32'(if16.square)};
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL rand_n16 i=%0d: got vld=%0b sq=%0d, expected vld=%0b sq=%0d",
                         i, act[32], act[31:0], e[32], e[31:0]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        if1.data = '0;  if1.in_valid = 1'b0;
        if3.data = '0;  if3.in_valid = 1'b0;
        if4.data = '0;  if4.in_valid = 1'b0;
        if8.data = '0;  if8.in_valid = 1'b0;
        if16.data = '0; if16.in_valid = 1'b0;
        #2;
        test_reset();
        test_stream();
        test_hold();
        test_midreset();
        test_n8_boundary();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/square_gen.md
Name: square_gen

Overview:
Parameterised unsigned squarer with a registered output. On each rising clock edge it captures an N-bit unsigned operand and presents its 2N-bit square one cycle later. It sits in the datapath wherever a pipelined x² term is needed, for example in power or magnitude computations. Throughput is one result per clock.

Parameters:
N, 3, operand width in bits (N >= 1); result width is 2N.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
data  input  N  unsigned operand to be squared
in_valid  input  1  qualifies data; tie high for continuous squaring
square  output  2N  registered unsigned result, data*data
out_valid  output  1  high when square holds a result captured from a valid input

Behaviour:
- Reset is synchronous only. On a rising edge with rst_n=0:
  - square <= 0
  - out_valid <= 0
  - rst_n overrides in_valid on that edge.
- Once out of reset, on each rising edge:
  - if in_valid=1: square <= data*data (full 2N-bit unsigned product, never truncated or saturated) and out_valid <= 1.
  - if in_valid=0: square holds its previous value and out_valid <= 0.
- Latency is exactly 1 clock. An operand sampled at edge k is visible on square after edge k; there is no combinational path from data to square.
- Throughput: a new operand is accepted every cycle. There are no stall or backpressure conditions.
- Arithmetic:
  - Operands are treated as unsigned.
  - The maximum result is (2^N-1)^2 = 2^(2N) - 2^(N+1) + 1, which always fits in 2N bits.
  - Bit 1 of square is always 0.
  - Bit 0 of square equals bit 0 of the captured operand.
- Implementation: the combinational squarer is an explicit partial-product array exploiting symmetry.
  - Diagonal terms: a_i·a_i = a_i.
  - Off-diagonal terms: 2·a_i·a_j for i<j.
  - The terms are summed by an adder tree sized from N via generate logic.
  - The result must be bit-exact to data*data for every N.
- Reset in mid-stream: a result in flight is discarded. The first valid result after rst_n returns high appears one edge after the first valid sample.
- X/Z on data while in_valid=0 must not propagate to square.

Test Plan:
- Reset: rst_n=0 for 2 edges with data=3'b111 and in_valid=1 -> square=0, out_valid=0 after each edge; release rst_n -> next edge gives square=49, out_valid=1.
- Exhaustive N=3 stream, in_valid=1, data=0,1,...,7 on consecutive edges -> square after each following edge = 0,1,4,9,16,25,36,49, with exactly 1-cycle lag and out_valid=1 throughout.
- Hold: data=5 with in_valid=1 on one edge, then data=6 with in_valid=0 -> square stays 25 and out_valid drops to 0.
- Mid-stream reset, N=3: data=6 captured, then rst_n=0 on the next edge while data=7 -> square=0, out_valid=0; the 36 result is discarded with no late appearance.
- Width/boundary with N=8: data=255 -> square=65025 (16'hFE01); data=128 -> 16384; data=1 -> 1. Random 1000-vector compare against the reference product for N=1, 4, 8, 16.
